// File: rtl/shift_ctr_gen.sv
// Run-time configurable ring / Johnson shift counter with load, terminal-count pulse,
// position decode and illegal-state flag. Define SHIFT_CTR_AUTOCORRECT_EN for step-time recovery.
module shift_ctr_gen #(
   parameter  int WIDTH = 4,
   localparam int POS_W = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic [POS_W-1:0] pos,
   output logic             tc,
   output logic             err
);

   typedef enum logic {
      JOHNSON = 1'b0,
      RING    = 1'b1
   } mode_e;

   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] seed_q;
   logic             err_c;
   logic [POS_W-1:0] pos_c;
   int unsigned      ones;
   int unsigned      trans;
   int unsigned      ring_k;

   function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
      return (m == RING) ? WIDTH'(1) : '0;
   endfunction

   assign seed_q = seed_of(mode_q);

   always_comb begin
      if (dir) begin
         shifted = {out_q[WIDTH-2:0],
                    (mode_q == RING) ? out_q[WIDTH-1] : ~out_q[WIDTH-1]};
      end else begin
         shifted = {(mode_q == RING) ? out_q[0] : ~out_q[0],
                    out_q[WIDTH-1:1]};
      end
   end

   // Johnson legality counts linear (non-wrapping) transitions: at most one means the
   // ones-run touches an end, which is exactly the set of 2*WIDTH reachable states.
   always_comb begin
      ones   = 0;
      trans  = 0;
      ring_k = 0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         ones = ones + {31'b0, out_q[i]};
         if (out_q[i]) ring_k = i;
      end
      for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
         trans = trans + {31'b0, out_q[i] ^ out_q[i+1]};
      end

      if (mode_q == RING) err_c = (ones != 1);
      else                err_c = (trans > 1);

      pos_c = '0;
      if (!err_c) begin
         if (mode_q == RING) begin
            pos_c = (ring_k == 0) ? '0 : POS_W'(WIDTH - ring_k);
         end else if (out_q[WIDTH-1]) begin
            pos_c = POS_W'(ones);
         end else if (ones != 0) begin
            pos_c = POS_W'(2*WIDTH - ones);
         end
      end
   end

   always_comb begin
      mode_d = mode_q;
      out_d  = out_q;
      tc_d   = 1'b0;
      if (load) begin
         out_d = load_val;
      end else if (mode_e'(mode) != mode_q) begin
         mode_d = mode_e'(mode);
         out_d  = seed_of(mode_e'(mode));
      end else if (en) begin
`ifdef SHIFT_CTR_AUTOCORRECT_EN
         if (err_c) begin
            out_d = seed_q;
         end else begin
            out_d = shifted;
            tc_d  = (shifted == seed_q);
         end
`else
         out_d = shifted;
         tc_d  = (shifted == seed_q);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= mode_e'(mode);
         out_q  <= seed_of(mode_e'(mode));
         tc_q   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         out_q  <= out_d;
         tc_q   <= tc_d;
      end
   end

   assign out = out_q;
   assign tc  = tc_q;
   assign err = err_c;
   assign pos = pos_c;

endmodule

// File: tb/tb_shift_ctr_gen.sv
// Bench for shift_ctr_gen at WIDTH 4, 2 and 8 against a sequence-enumeration reference model.
module tb_shift_ctr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1, en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
   logic [31:0] lv = '0;

   logic [3:0] o4; logic [2:0] p4; logic t4, e4;
   logic [1:0] o2; logic [1:0] p2; logic t2, e2;
   logic [7:0] o8; logic [3:0] p8; logic t8, e8;

   int tests  = 0;
   int failed = 0;

`ifdef SHIFT_CTR_AUTOCORRECT_EN
   localparam bit AC = 1'b1;
`else
   localparam bit AC = 1'b0;
`endif

   always #5 clk = ~clk;

   shift_ctr_gen #(.WIDTH(4)) d4 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
      .load(load), .load_val(lv[3:0]), .out(o4), .pos(p4), .tc(t4), .err(e4));
   shift_ctr_gen #(.WIDTH(2)) d2 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
      .load(load), .load_val(lv[1:0]), .out(o2), .pos(p2), .tc(t2), .err(e2));
   shift_ctr_gen #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
      .load(load), .load_val(lv[7:0]), .out(o8), .pos(p8), .tc(t8), .err(e8));

   logic [31:0] dout[3];
   logic [31:0] dpos[3];
   logic        dtc[3];
   logic        derr[3];

   always_comb begin
      dout[0] = 32'(o4); dpos[0] = 32'(p4); dtc[0] = t4; derr[0] = e4;
      dout[1] = 32'(o2); dpos[1] = 32'(p2); dtc[1] = t2; derr[1] = e2;
      dout[2] = 32'(o8); dpos[2] = 32'(p8); dtc[2] = t8; derr[2] = e8;
   end

   int          widths[3] = '{4, 2, 8};
   logic [31:0] m_out[3];
   logic        m_mode[3];
   logic        m_tc[3];

   function automatic logic [31:0] mask_of(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // One step straight from the shift rules on a plain integer value
   function automatic logic [31:0] step_of(input logic [31:0] v, input int w,
                                           input logic m, input logic d);
      logic lsb, msb;
      lsb = v[0];
      msb = v[w-1];
      if (!d) return (v >> 1) | ({31'b0, m ? lsb : ~lsb} << (w-1));
      return ((v << 1) | {31'b0, m ? msb : ~msb}) & mask_of(w);
   endfunction

   // Position = number of right steps from the seed; -1 when never reached (illegal)
   function automatic int find_pos(input logic [31:0] v, input int w, input logic m);
      logic [31:0] cur;
      int          period;
      cur    = m ? 32'd1 : 32'd0;
      period = m ? w : 2*w;
      for (int i = 0; i < period; i++) begin
         if (cur == v) return i;
         cur = step_of(cur, w, m, 1'b0);
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int          w;
         logic [31:0] nxt;
         w = widths[i];
         if (rst) begin
            m_mode[i] = mode;
            m_out[i]  = mode ? 32'd1 : 32'd0;
            m_tc[i]   = 1'b0;
         end else if (load) begin
            m_out[i] = lv & mask_of(w);
            m_tc[i]  = 1'b0;
         end else if (mode != m_mode[i]) begin
            m_mode[i] = mode;
            m_out[i]  = mode ? 32'd1 : 32'd0;
            m_tc[i]   = 1'b0;
         end else if (en) begin
            if (AC && find_pos(m_out[i], w, m_mode[i]) < 0) begin
               m_out[i] = m_mode[i] ? 32'd1 : 32'd0;
               m_tc[i]  = 1'b0;
            end else begin
               nxt      = step_of(m_out[i], w, m_mode[i], dir);
               m_out[i] = nxt;
               m_tc[i]  = (nxt == (m_mode[i] ? 32'd1 : 32'd0));
            end
         end else begin
            m_tc[i] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         int p;
         p = find_pos(m_out[i], widths[i], m_mode[i]);
         check($sformatf("w%0d out", widths[i]), dout[i], m_out[i]);
         check($sformatf("w%0d pos", widths[i]), dpos[i], (p < 0) ? 32'd0 : 32'(p));
         check($sformatf("w%0d tc", widths[i]), {31'b0, dtc[i]}, {31'b0, m_tc[i]});
         check($sformatf("w%0d err", widths[i]), {31'b0, derr[i]}, {31'b0, p < 0});
      end
   endtask

   logic [3:0] exp_j[8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                            4'b0111, 4'b0011, 4'b0001, 4'b0000};
   logic [3:0] exp_r[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [2:0] exp_rp[4] = '{3'd3, 3'd2, 3'd1, 3'd0};

   initial begin
      int tc2_cnt, tc8_cnt;

      // reset into Johnson
      rst = 1'b1; mode = 1'b0;
      tick();
      check("rst out", 32'(o4), 32'd0);
      check("rst tc", {31'b0, t4}, 32'd0);

      // Johnson right full period
      rst = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("johnson seq", 32'(o4), 32'(exp_j[i]));
         check("johnson tc", {31'b0, t4}, {31'b0, i == 7});
      end

      // ring left then hold
      mode = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ring seq", 32'(o4), 32'(exp_r[i]));
         check("ring pos", 32'(p4), 32'(exp_rp[i]));
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold out", 32'(o4), 32'd1);
         check("hold tc", {31'b0, t4}, 32'd0);
      end

      // illegal Johnson load
      mode = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; load = 1'b1; lv = 32'h6;
      tick();
      check("illegal err", {31'b0, e4}, 32'd1);
      check("illegal pos", 32'(p4), 32'd0);
      load = 1'b0; en = 1'b1; dir = 1'b0;
      tick();
      check("illegal step out", 32'(o4), AC ? 32'd0 : 32'hB);
      check("illegal step err", {31'b0, e4}, AC ? 32'd0 : 32'd1);

      // mode change overrides en
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("pre-switch out", 32'(o4), 32'hE);
      mode = 1'b1;
      tick();
      check("switch out", 32'(o4), 32'd1);
      check("switch tc", {31'b0, t4}, 32'd0);
      tick();
      check("post-switch out", 32'(o4), 32'h8);

      // load beats en; rst beats load and en
      load = 1'b1; lv = 32'h4;
      tick();
      check("load+en out", 32'(o4), 32'h4);
      rst = 1'b1;
      tick();
      check("rst+load out", 32'(o4), 32'd1);
      check("rst+load tc", {31'b0, t4}, 32'd0);
      rst = 1'b0; load = 1'b0;

      // Johnson full periods both directions on W=2 and W=8
      mode = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; dir = 1'b0; en = 1'b1;
      tc2_cnt = 0; tc8_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         tc2_cnt += int'(t2);
         tc8_cnt += int'(t8);
      end
      check("w2 period tc count", 32'(tc2_cnt), 32'd4);
      check("w8 period tc count", 32'(tc8_cnt), 32'd1);
      dir = 1'b1;
      tick();
      check("w8 wrap pos", 32'(p8), 32'd15);
      check("w2 wrap pos", 32'(p2), 32'd3);
      tc2_cnt = 0; tc8_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         tc2_cnt += int'(t2);
         tc8_cnt += int'(t8);
      end
      check("w8 left tc count", 32'(tc8_cnt), 32'd1);
      check("w2 left tc count", 32'(tc2_cnt), 32'd4);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         rst  = ($urandom % 50) == 0;
         load = ($urandom % 12) == 0;
         lv   = $urandom;
         if (($urandom % 25) == 0) mode = ~mode;
         dir  = 1'($urandom);
         en   = ($urandom % 4) != 0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
